// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for the clock monitor and its synchroniser.
package clk_mon_pkg;

    // Default width of the period counter and period_o.
    localparam int unsigned PERIOD_W_DEF = 16;

    // Measurement FSM encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_MEASURE = 2'd1;
    localparam state_t ST_TIMEOUT = 2'd2;

    // Unsigned window test: lo <= val <= hi, where lo = exp_v - tol clamped
    // at 0 and hi = exp_v + tol. Computed one bit wider so hi cannot overflow.
    function automatic logic in_tolerance(input logic [31:0] val,
                                          input logic [31:0] exp_v,
                                          input logic [31:0] tol);
        logic [32:0] lo;
        logic [32:0] hi;
        if (exp_v > tol) begin
            lo = {1'b0, exp_v - tol};
        end else begin
            lo = 33'd0;
        end
        hi = {1'b0, exp_v} + {1'b0, tol};
        in_tolerance = ({1'b0, val} >= lo) && ({1'b0, val} <= hi);
    endfunction

endpackage

// File: rtl/clk_mon_sync_edge.sv
// Two-flop synchroniser plus history flop for an asynchronous input.
// rise_o is a one-cycle, clk_i-domain pulse on each synchronised rising edge.
module sync_edge (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic rise_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Synchroniser chain; s3_q remembers the previous synchronised level.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= async_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/clk_mon.sv
// Clock monitor: measures the period of an asynchronous clock in clk_i cycles,
// offers each measurement on a valid/ready port and reports lock / loss of clock.
module clk_mon
    import clk_mon_pkg::*;
#(
    parameter int unsigned PERIOD_W   = PERIOD_W_DEF,
    parameter int unsigned MAX_PERIOD = 65535,
    parameter int unsigned EXP_PERIOD = 16,
    parameter int unsigned TOL        = 0,
    parameter int unsigned LOCK_CNT   = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                mon_i,
    output logic [PERIOD_W-1:0] period_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                overrun_o,
    output logic                edge_o,
    output logic                locked_o,
    output logic                timeout_o
);

    localparam int unsigned         MATCH_W  = $clog2(LOCK_CNT + 1);
    localparam logic [PERIOD_W-1:0] MAX_CNT  = PERIOD_W'(MAX_PERIOD);
    localparam logic [MATCH_W-1:0]  LOCK_VAL = MATCH_W'(LOCK_CNT);

    logic                rise_s;
    logic                capture_s;
    state_t              state_q,   state_d;
    logic [PERIOD_W-1:0] cnt_q,     cnt_d;
    logic [PERIOD_W-1:0] period_q,  period_d;
    logic                valid_q,   valid_d;
    logic                overrun_q, overrun_d;
    logic                edge_q;
    logic                locked_q,  locked_d;
    logic                timeout_q, timeout_d;
    logic [MATCH_W-1:0]  match_q,   match_d;

    sync_edge u_sync_edge (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .async_i (mon_i),
        .rise_o  (rise_s)
    );

    // Next-state logic: FSM, period counter, capture/handshake and lock tracking.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        locked_d  = locked_q;
        timeout_d = timeout_q;
        match_d   = match_q;
        capture_s = 1'b0;

        // A completed handshake empties the output register unless a capture
        // below overrides it in the same cycle.
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                // The first edge only arms the counter; no period is known yet.
                if (rise_s) begin
                    state_d = ST_MEASURE;
                    cnt_d   = PERIOD_W'(1);
                end else begin
                    cnt_d   = {PERIOD_W{1'b0}};
                end
            end
            ST_MEASURE: begin
                if (rise_s) begin
                    capture_s = 1'b1;
                    cnt_d     = PERIOD_W'(1);
                end else if (cnt_q == MAX_CNT) begin
                    // Loss of clock: saturate, drop lock, restart matching later.
                    state_d   = ST_TIMEOUT;
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    match_d   = {MATCH_W{1'b0}};
                end else begin
                    cnt_d     = cnt_q + PERIOD_W'(1);
                end
            end
            ST_TIMEOUT: begin
                locked_d = 1'b0;
                match_d  = {MATCH_W{1'b0}};
                // Re-arm on the next edge; the gap is not a valid period.
                if (rise_s) begin
                    state_d   = ST_MEASURE;
                    cnt_d     = PERIOD_W'(1);
                    timeout_d = 1'b0;
                end else begin
                    cnt_d     = cnt_q;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = {PERIOD_W{1'b0}};
                timeout_d = 1'b0;
                locked_d  = 1'b0;
                match_d   = {MATCH_W{1'b0}};
            end
        endcase

        // New measurement always wins over pending data; flag the loss only
        // if the old value was neither consumed now nor earlier.
        if (capture_s) begin
            period_d  = cnt_q;
            valid_d   = 1'b1;
            overrun_d = valid_q & ~ready_i;
            if (in_tolerance(32'(cnt_q), 32'(EXP_PERIOD), 32'(TOL))) begin
                if (match_q == LOCK_VAL) begin
                    match_d = match_q;
                end else begin
                    match_d = match_q + MATCH_W'(1);
                end
            end else begin
                match_d = {MATCH_W{1'b0}};
            end
            locked_d = (match_d == LOCK_VAL);
        end else begin
            period_d = period_q;
        end
    end

    // State and output registers; reset discards any partial or pending data.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {PERIOD_W{1'b0}};
            period_q  <= {PERIOD_W{1'b0}};
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            edge_q    <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
            match_q   <= {MATCH_W{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            edge_q    <= rise_s;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
            match_q   <= match_d;
        end
    end

    assign period_o  = period_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;
    assign edge_o    = edge_q;
    assign locked_o  = locked_q;
    assign timeout_o = timeout_q;

endmodule
